// File: rtl/pkt_mem_pkg.sv
// Shared sizes, host handshake state encoding and the width legality rule for pkt_mem.
package pkt_mem_pkg;

  localparam int unsigned PKT_MEM_DEPTH = 4096;
  localparam int unsigned PKT_MEM_NB    = 8;

  typedef enum logic {
    PKT_MEM_HOST_IDLE,
    PKT_MEM_HOST_ACK
  } host_state_t;

  // An access moves between 1 and nb bytes; anything else is an error.
  function automatic logic width_ok(input logic [3:0] width, input int unsigned nb);
    return (width != 4'd0) && (32'(width) <= nb);
  endfunction

endpackage

// File: rtl/pkt_mem_byte_bank.sv
// One byte lane of the packet memory: single-port synchronous RAM, registered read.
module byte_bank #(
  parameter int unsigned ROW_W = 9
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [ROW_W-1:0] row,
  input  logic [7:0]       wd,
  output logic [7:0]       rd
);

  localparam int unsigned ROWS = 1 << ROW_W;

  logic [7:0] ram [ROWS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) ram[row] <= wd;
      rd <= ram[row];
    end
  end

endmodule

// File: rtl/pkt_mem.sv
// Byte-addressable packet/table memory: processor port with absolute priority plus a
// 4-phase host port, both served by one rotate/mask path over NB byte-lane banks.
module pkt_mem
  import pkt_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH_BYTES = PKT_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_width_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [3:0]        host_width_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic [DATA_W-1:0] host_data_o,
  output logic              host_ack_o,
  input  logic              err_clr_i,
  output logic              err_o
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned RW = $clog2(DEPTH_BYTES / NB);
  localparam int unsigned EW = ADDR_W + 1;

  host_state_t state, state_next;
  logic        host_go;

  logic              acc_en, acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_width;
  logic [DATA_W-1:0] acc_data;

  logic [EW-1:0] byte_addr [NB];
  logic [NB-1:0] byte_ok;
  logic          range_err;
  logic          err_hit;

  logic [LW-1:0] lane_k   [NB];
  logic [RW-1:0] lane_row [NB];
  logic [7:0]    lane_wd  [NB];
  logic [7:0]    lane_q   [NB];
  logic [NB-1:0] lane_we;

  logic              proc_rd_q, host_rd_q;
  logic [LW-1:0]     rot_q;
  logic [NB-1:0]     mask_q;
  logic [DATA_W-1:0] rd_aligned;
  logic [DATA_W-1:0] mem_hold_q, host_hold_q;

  assign host_go = !rst && (state == PKT_MEM_HOST_IDLE) && host_req_i && !mem_ce_i;

  always_comb begin
    acc_en    = !rst && (mem_ce_i || host_go);
    acc_we    = host_we_i;
    acc_addr  = host_addr_i;
    acc_width = host_width_i;
    acc_data  = host_data_i;
    if (mem_ce_i) begin
      acc_we    = mem_we_i;
      acc_addr  = mem_addr_i;
      acc_width = mem_width_i;
      acc_data  = mem_data_i;
    end
  end

  // Byte k of the access lives at addr+k; the extra address bit keeps addr+k from wrapping.
  always_comb begin
    byte_ok   = '0;
    range_err = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      byte_addr[k] = {1'b0, acc_addr} + EW'(k);
      if (width_ok(acc_width, NB) && (k < 32'(acc_width))) begin
        if (byte_addr[k] < EW'(DEPTH_BYTES)) byte_ok[k] = 1'b1;
        else                                 range_err  = 1'b1;
      end
    end
  end

  assign err_hit = acc_en && (!width_ok(acc_width, NB) || range_err);

  // Bank j serves access byte k = (j - addr) mod NB, so the rotation is a lane-index subtract.
  always_comb begin
    lane_we = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      lane_k[j]   = LW'(LW'(j) - acc_addr[LW-1:0]);
      lane_row[j] = byte_addr[lane_k[j]][LW +: RW];
      lane_we[j]  = acc_en && acc_we && byte_ok[lane_k[j]];
      lane_wd[j]  = acc_data[8*lane_k[j] +: 8];
    end
  end

  for (genvar j = 0; j < NB; j++) begin : g_lane
    byte_bank #(.ROW_W(RW)) u_bank (
      .clk (clk),
      .en  (acc_en),
      .we  (lane_we[j]),
      .row (lane_row[j]),
      .wd  (lane_wd[j]),
      .rd  (lane_q[j])
    );
  end

  always_ff @(posedge clk) begin
    if (acc_en) begin
      rot_q  <= acc_addr[LW-1:0];
      mask_q <= byte_ok;
    end
  end

  always_comb begin
    rd_aligned = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (mask_q[k]) rd_aligned[8*k +: 8] = lane_q[LW'(rot_q + LW'(k))];
    end
  end

  // Bank outputs move on every access, so each port keeps its own copy of its last read.
  assign mem_data_o  = proc_rd_q ? rd_aligned : mem_hold_q;
  assign host_data_o = host_rd_q ? rd_aligned : host_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      proc_rd_q   <= 1'b0;
      host_rd_q   <= 1'b0;
      mem_hold_q  <= '0;
      host_hold_q <= '0;
      err_o       <= 1'b0;
    end else begin
      proc_rd_q   <= mem_ce_i && !mem_we_i;
      host_rd_q   <= host_go && !host_we_i;
      mem_hold_q  <= mem_data_o;
      host_hold_q <= host_data_o;
      if (err_hit)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= PKT_MEM_HOST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PKT_MEM_HOST_IDLE: if (host_go)     state_next = PKT_MEM_HOST_ACK;
      PKT_MEM_HOST_ACK:  if (!host_req_i) state_next = PKT_MEM_HOST_IDLE;
      default:                            state_next = PKT_MEM_HOST_IDLE;
    endcase
  end

  assign host_ack_o = (state == PKT_MEM_HOST_ACK);

endmodule

// File: tb/tb_pkt_mem.sv
// Bench for pkt_mem: directed vector table, host handshake sequences and random
// processor traffic checked against a byte-array reference model.
module tb_pkt_mem;

  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_width_i;
  logic [63:0] mem_data_i, mem_data_o;
  logic        host_req_i, host_we_i;
  logic [31:0] host_addr_i;
  logic [3:0]  host_width_i;
  logic [63:0] host_data_i, host_data_o;
  logic        host_ack_o;
  logic        err_clr_i, err_o;

  pkt_mem #(.ADDR_W(32), .DATA_W(64), .DEPTH_BYTES(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ce_i     (mem_ce_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_width_i  (mem_width_i),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_width_i (host_width_i),
    .host_data_i  (host_data_i),
    .host_data_o  (host_data_o),
    .host_ack_o   (host_ack_o),
    .err_clr_i    (err_clr_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0]  m_mem [DEPTH];
  logic [63:0] m_hold;
  bit          m_err;

  typedef struct {
    bit          ce;
    bit          we;
    logic [31:0] a;
    logic [3:0]  w;
    logic [63:0] d;
    bit          clr;
    logic [63:0] exp_d;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte-granular memory, each access byte checked on its own.
  task automatic model_access(input bit we, input logic [31:0] a, input int w,
                              input logic [63:0] d, output logic [63:0] rd, output bit bad);
    longint unsigned ba;
    rd  = '0;
    bad = 1'b0;
    if (w < 1 || w > 8) begin
      bad = 1'b1;
      return;
    end
    for (int k = 0; k < w; k++) begin
      ba = 64'(a) + 64'(k);
      if (ba >= 64'(DEPTH)) bad = 1'b1;
      else if (we)          m_mem[int'(ba)] = d[8*k +: 8];
      else                  rd[8*k +: 8] = m_mem[int'(ba)];
    end
  endtask

  // Called at a negedge: drives one processor cycle and returns at the next negedge.
  task automatic proc_op(input bit ce, input bit we, input logic [31:0] a, input logic [3:0] w,
                         input logic [63:0] d, input bit clr);
    logic [63:0] rd;
    bit bad;
    mem_ce_i = ce; mem_we_i = we; mem_addr_i = a; mem_width_i = w; mem_data_i = d;
    err_clr_i = clr;
    bad = 1'b0;
    if (ce) begin
      model_access(we, a, int'(w), d, rd, bad);
      if (!we) m_hold = rd;
    end
    if (bad)      m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    @(negedge clk);
    mem_ce_i = 1'b0;
    err_clr_i = 1'b0;
  endtask

  task automatic host_xfer(input bit we, input logic [31:0] a, input logic [3:0] w,
                           input logic [63:0] d, input string nm);
    logic [63:0] rd;
    bit bad;
    host_req_i = 1'b1; host_we_i = we; host_addr_i = a; host_width_i = w; host_data_i = d;
    model_access(we, a, int'(w), d, rd, bad);
    if (bad) m_err = 1'b1;
    @(negedge clk);
    check({nm, " ack"}, 64'(host_ack_o), 64'(1));
    if (!we) check({nm, " data"}, host_data_o, rd);
    check({nm, " err"}, 64'(err_o), 64'(m_err));
    check({nm, " proc hold"}, mem_data_o, m_hold);
    @(negedge clk);
    check({nm, " ack held"}, 64'(host_ack_o), 64'(1));
    if (!we) check({nm, " data held"}, host_data_o, rd);
    host_req_i = 1'b0;
    @(negedge clk);
    check({nm, " ack drop"}, 64'(host_ack_o), 64'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    bit          bad;
    bit          ce, we, clr;
    logic [31:0] a;
    logic [3:0]  w;

    rst = 1'b1;
    mem_ce_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_width_i = '0; mem_data_i = '0;
    host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_width_i = '0; host_data_i = '0;
    err_clr_i = 0;
    m_hold = '0;
    m_err  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset mem_data", mem_data_o, 64'h0);
    check("reset host_data", host_data_o, 64'h0);
    check("reset ack", 64'(host_ack_o), 64'h0);
    check("reset err", 64'(err_o), 64'h0);
    rst = 1'b0;

    for (int unsigned i = 0; i < DEPTH; i += 8) proc_op(1, 1, i, 4'd8, 64'h0, 0);
    check("preclear err", 64'(err_o), 64'h0);

    //              ce we addr          w     data                   clr exp_d                  exp_err
    tbl.push_back('{1'b0, 1'b0, 32'h0,        4'd0, 64'h0,                 1'b1, 64'h0,                 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h3D,       4'd4, 64'hAABBCCDD,          1'b0, 64'h0,                 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h3C,       4'd8, 64'h0,                 1'b0, 64'h000000AABBCCDD00,  1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h40,       4'd8, 64'h1122334455667788,  1'b0, 64'h000000AABBCCDD00,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h40,       4'd8, 64'h0,                 1'b0, 64'h1122334455667788,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h3C,       4'd8, 64'h0,                 1'b0, 64'h55667788BBCCDD00,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h40,       4'd2, 64'h0,                 1'b0, 64'h7788,              1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h40,       4'd0, 64'h0,                 1'b0, 64'h0,                 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,        4'd0, 64'h0,                 1'b1, 64'h0,                 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'hFFE,      4'd4, 64'h99887766,          1'b0, 64'h0,                 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,        4'd0, 64'h0,                 1'b1, 64'h0,                 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'hFFC,      4'd4, 64'h0,                 1'b0, 64'h77660000,          1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'hFFE,      4'd4, 64'h0,                 1'b0, 64'h7766,              1'b1});
    tbl.push_back('{1'b1, 1'b0, 32'h3D,       4'd0, 64'h0,                 1'b1, 64'h0,                 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,        4'd0, 64'h0,                 1'b1, 64'h0,                 1'b0});
    tbl.push_back('{1'b1, 1'b1, 32'h44,       4'd9, 64'hFFFFFFFFFFFFFFFF,  1'b0, 64'h0,                 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,        4'd0, 64'h0,                 1'b1, 64'h0,                 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h44,       4'd4, 64'h0,                 1'b0, 64'h11223344,          1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'hFFFFFFFE, 4'd4, 64'h0,                 1'b0, 64'h0,                 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0,        4'd0, 64'h0,                 1'b1, 64'h0,                 1'b0});

    foreach (tbl[i]) begin
      proc_op(tbl[i].ce, tbl[i].we, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].clr);
      check($sformatf("vec%0d data", i), mem_data_o, tbl[i].exp_d);
      check($sformatf("vec%0d err", i), 64'(err_o), 64'(tbl[i].exp_err));
    end

    for (int n = 0; n < 400; n++) begin
      ce  = ($urandom % 4) != 0;
      we  = $urandom % 2;
      a   = (($urandom % 8) == 0) ? 32'(DEPTH - 8 + ($urandom % 12)) : 32'($urandom % DEPTH);
      w   = 4'($urandom % 10);
      clr = ($urandom % 6) == 0;
      proc_op(ce, we, a, w, {$urandom, $urandom}, clr);
      check($sformatf("rand%0d data", n), mem_data_o, m_hold);
      check($sformatf("rand%0d err", n), 64'(err_o), 64'(m_err));
    end
    proc_op(0, 0, 0, 0, 0, 1);
    check("rand clr err", 64'(err_o), 64'h0);

    host_xfer(1, 32'h100, 4'd8, 64'hCAFEBABEDEADBEEF, "host wr");
    host_xfer(0, 32'h100, 4'd8, 64'h0, "host rd");
    host_xfer(0, 32'h103, 4'd3, 64'h0, "host rd unaligned");
    host_xfer(1, 32'hFFF, 4'd2, 64'hA5A5, "host wr oob");
    host_xfer(0, 32'hFFF, 4'd1, 64'h0, "host rd last");
    host_xfer(0, 32'h100, 4'd0, 64'h0, "host rd w0");

    // Processor holds the port for five cycles; the host must wait in IDLE.
    host_req_i = 1; host_we_i = 0; host_addr_i = 32'h100; host_width_i = 4'd8;
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h104; mem_width_i = 4'd4;
    model_access(0, 32'h104, 4, 0, rd, bad);
    m_hold = rd;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("contend%0d ack", c), 64'(host_ack_o), 64'h0);
      check($sformatf("contend%0d proc data", c), mem_data_o, m_hold);
    end
    mem_ce_i = 0;
    model_access(0, 32'h100, 8, 0, rd, bad);
    @(negedge clk);
    check("contend ack rise", 64'(host_ack_o), 64'h1);
    check("contend host data", host_data_o, rd);
    host_req_i = 0;
    @(negedge clk);
    check("contend ack fall", 64'(host_ack_o), 64'h0);

    // Reset lands while the host write is being acknowledged; err is still set from w=0.
    proc_op(1, 0, 32'h100, 4'd8, 0, 0);
    check("pre-rst proc data", mem_data_o, m_hold);
    host_req_i = 1; host_we_i = 1; host_addr_i = 32'h200; host_width_i = 4'd8;
    host_data_i = 64'h0123456789ABCDEF;
    model_access(1, 32'h200, 8, 64'h0123456789ABCDEF, rd, bad);
    @(negedge clk);
    check("pre-rst ack", 64'(host_ack_o), 64'h1);
    rst = 1;
    @(negedge clk);
    check("rst ack", 64'(host_ack_o), 64'h0);
    check("rst mem_data", mem_data_o, 64'h0);
    check("rst host_data", host_data_o, 64'h0);
    check("rst err", 64'(err_o), 64'h0);
    rst = 0;
    host_req_i = 0;
    m_hold = '0;
    m_err = 1'b0;
    @(negedge clk);
    check("post-rst ack", 64'(host_ack_o), 64'h0);
    proc_op(1, 0, 32'h200, 4'd8, 0, 0);
    check("post-rst readback", mem_data_o, 64'h0123456789ABCDEF);
    host_xfer(0, 32'h200, 4'd8, 64'h0, "post-rst host rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
